// File: rtl/busca_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, default
// geometry and the NOP word driven whenever no instruction is offered.
package busca_pkg;

    localparam int         DEPTH_DEF  = 32;
    localparam int         ADDR_W_DEF = 5;
    localparam logic [7:0] NOP        = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIM  = 2'd2
    } estado_t;

endpackage

// File: rtl/memoria_instr.sv
// Program memory: DEPTH x 8, synchronous write, combinational read.
// Contents are deliberately not reset so a program survives rst_n.
module memoria_instr #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch unit: issues prog_len words from program memory over a
// valid/ready handshake, one per cycle when the consumer keeps ready high.
module busca_instrucao
    import busca_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              halt,
    output logic [7:0]        instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              done
);

    estado_t           r_estado;
    estado_t           w_prox;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_instr;
    logic [ADDR_W:0]   r_len;

    logic              w_xfer;
    logic              w_ultimo;
    logic [ADDR_W:0]   w_pc_inc;
    logic              w_we;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [7:0]        w_rd_data;

    assign w_xfer   = (r_estado == RUN) && instr_ready;
    assign w_pc_inc = {1'b0, r_pc} + {{ADDR_W{1'b0}}, 1'b1};
    assign w_ultimo = (w_pc_inc == r_len);
    assign w_we     = load_en && (r_estado != RUN);
    // Only the non-final pc+1 is ever consumed, so the read never passes DEPTH-1.
    assign w_rd_addr = (r_estado == RUN) ? w_pc_inc[ADDR_W-1:0] : '0;

    memoria_instr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            IDLE: begin
                if (start) begin
                    w_prox = (prog_len != '0) ? RUN : FIM;
                end
            end
            RUN: begin
                if (halt) begin
                    w_prox = IDLE;
                end else if (w_xfer && w_ultimo) begin
                    w_prox = FIM;
                end
            end
            FIM:     w_prox = IDLE;
            default: w_prox = IDLE;
        endcase
    end

    // Halt wins over a coincident transfer: pc is left where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_instr <= NOP;
            r_len   <= '0;
        end else begin
            case (r_estado)
                IDLE: begin
                    if (start) begin
                        r_instr <= w_rd_data;
                        r_pc    <= '0;
                        r_len   <= prog_len;
                    end
                end
                RUN: begin
                    if (!halt && w_xfer && !w_ultimo) begin
                        r_pc    <= w_pc_inc[ADDR_W-1:0];
                        r_instr <= w_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign running     = (r_estado == RUN);
    assign instr_valid = running;
    assign instr       = running ? r_instr : NOP;
    assign pc          = r_pc;
    assign done        = (r_estado == FIM);

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of 8-bit instruction words held.
REQ-002 SHALL have parameter ADDR_W, default 5, equal to clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_en  input  1  write strobe for program memory.
REQ-006 SHALL have port load_addr  input  ADDR_W  program memory write address.
REQ-007 SHALL have port load_data  input  8  program memory write data.
REQ-008 SHALL have port prog_len  input  ADDR_W+1  number of instructions to issue, 0..DEPTH, sampled on start.
REQ-009 SHALL have port start  input  1  begin issuing from address 0.
REQ-010 SHALL have port halt  input  1  synchronous abort of the current program.
REQ-011 SHALL have port instr  output  8  instruction word to the processor instr input.
REQ-012 SHALL have port instr_valid  output  1  instr holds an instruction not yet accepted.
REQ-013 SHALL have port instr_ready  input  1  consumer accepts instr this cycle.
REQ-014 SHALL have port pc  output  ADDR_W  address of the word currently on instr.
REQ-015 SHALL have port running  output  1  high in state RUN.
REQ-016 SHALL have port done  output  1  one-cycle pulse when a program completes normally.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, FIM; IDLE -> RUN on start with prog_len != 0; IDLE -> FIM on start with prog_len == 0; RUN -> FIM on the final transfer; RUN -> IDLE on halt; FIM -> IDLE unconditionally after one cycle.
REQ-018 SHALL, on start in IDLE, register instr <= mem[0], pc <= 0, and the sampled length, giving instr_valid = 1 on the next cycle (latency 1).
REQ-019 SHALL define a transfer as instr_valid && instr_ready at a rising edge.
REQ-020 SHALL, on a non-final transfer, load pc <= pc+1 and instr <= mem[pc+1] at the same edge, keeping instr_valid high (back-to-back, one instruction per cycle).
REQ-021 SHALL hold instr and pc stable while instr_valid && !instr_ready.
REQ-022 SHALL treat the transfer with pc == length-1 as final: instr_valid low next cycle, state FIM, done = 1 for exactly that cycle.
REQ-023 SHALL never let pc wrap: with prog_len == DEPTH the final address is DEPTH-1 and no read beyond it occurs.
REQ-024 SHALL drive instr_valid = 0, instr = 8'hFF (NOP) in IDLE and FIM.
REQ-025 SHALL, on halt in RUN, go to IDLE next cycle with instr_valid = 0 and no done pulse; halt has priority over a simultaneous transfer, and that transfer's instruction is counted as accepted but pc does not advance.
REQ-026 SHALL ignore start when not in IDLE and halt when not in RUN.
REQ-027 SHALL write mem[load_addr] <= load_data on load_en only in IDLE or FIM; load_en in RUN SHALL be ignored.
REQ-028 SHALL, when load_en and start coincide in IDLE, perform the write and start from the pre-write contents of address 0.

Reset
REQ-029 SHALL on rst_n low, immediately and regardless of clk: state IDLE, pc = 0, instr = 8'hFF, instr_valid = 0, running = 0, done = 0, sampled length = 0.
REQ-030 SHALL not clear program memory on reset; reset mid-RUN aborts with no done pulse.

Structure
REQ-031 SHALL place the state enum, default DEPTH/ADDR_W, and the NOP constant 8'hFF in shared package busca_pkg.
REQ-032 SHALL contain one sub-module memoria_instr: DEPTH x 8, one synchronous write port, one combinational read port.

Verification
REQ-033 SHALL cover: load mem[0..2] = 00,01,02, prog_len=3, start, instr_ready=1 -> instr 00,01,02 on three consecutive cycles after 1-cycle latency, then done pulse, pc 0,1,2.
REQ-034 SHALL cover: same program, instr_ready low for 4 cycles at pc=1 -> instr stays 01, instr_valid stays 1, pc stays 1, then resumes with 02.
REQ-035 SHALL cover: prog_len=0, start -> no instr_valid, done = 1 one cycle later, back to IDLE.
REQ-036 SHALL cover: prog_len=32, all words loaded, ready always high -> 32 transfers, final pc = 31, no wrap to 0.
REQ-037 SHALL cover: halt asserted at pc=1 with ready high -> instr_valid 0 next cycle, no done, running 0; then start replays from mem[0].
REQ-038 SHALL cover: rst_n pulsed low between clock edges mid-RUN -> outputs reach reset values immediately; memory contents preserved on next start.
